// File: rtl/memory_v3_pkg.sv
// Shared definitions for memory_v3: MMIO offsets, window select enum and hex glyph table.
package memory_v3_pkg;

    // Offsets are subtracted from 2^ADDR_W to locate each MMIO word
    localparam int BTN_STATE_OFS = 4;
    localparam int BTN_EDGE_OFS  = 3;
    localparam int SEG_REG_OFS   = 2;
    localparam int RSVD_OFS      = 1;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_BTN_STATE,
        SEL_BTN_EDGE,
        SEL_SEG,
        SEL_RSVD
    } mmio_sel_t;

    // Active-high gfedcba segment pattern for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/memory_v3_button_conditioner.sv
// Push-button conditioning: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce is built only when MEMORY_V3_DEBOUNCE_EN is defined.
module button_conditioner #(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_BUTTONS-1:0] i_btn,
    output logic [N_BUTTONS-1:0] o_state,
    output logic [N_BUTTONS-1:0] o_rise
);

    logic [N_BUTTONS-1:0] r_sync1;
    logic [N_BUTTONS-1:0] r_sync2;
    logic [N_BUTTONS-1:0] r_prev;
    logic [N_BUTTONS-1:0] w_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MEMORY_V3_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0]     r_cnt [N_BUTTONS];
    logic [N_BUTTONS-1:0] r_stable;

    // Flip on the edge where the disagreement count would reach DEBOUNCE_CYCLES
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stable <= '0;
            for (int i = 0; i < N_BUTTONS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable[i] <= ~r_stable[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_state = r_stable;
`else
    assign w_state = r_sync2;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_prev <= '0;
        else       r_prev <= w_state;
    end

    assign o_state = w_state;
    assign o_rise  = w_state & ~r_prev;

endmodule

// File: rtl/memory_v3.sv
// Data memory with byte strobes, registered read port and a 4-word MMIO window
// (buttons, edge flags, seven-segment). Optional debounce: MEMORY_V3_DEBOUNCE_EN.
module memory_v3
    import memory_v3_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 10,
    parameter int N_BUTTONS       = 4,
    parameter int N_SEG           = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_W-1:0]     data_out,
    output logic                  read_valid,
    input  logic [N_BUTTONS-1:0]  button_array,
    output logic [7*N_SEG-1:0]    seg
);

    localparam int NB    = DATA_W / 8;
    localparam int SEG_W = 4 * N_SEG;

    localparam logic [ADDR_W-1:0] A_BTN_STATE = ADDR_W'((2 ** ADDR_W) - BTN_STATE_OFS);
    localparam logic [ADDR_W-1:0] A_BTN_EDGE  = ADDR_W'((2 ** ADDR_W) - BTN_EDGE_OFS);
    localparam logic [ADDR_W-1:0] A_SEG       = ADDR_W'((2 ** ADDR_W) - SEG_REG_OFS);
    localparam logic [ADDR_W-1:0] A_RSVD      = ADDR_W'((2 ** ADDR_W) - RSVD_OFS);

    logic [DATA_W-1:0]    r_ram [2 ** ADDR_W];
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_read_valid;
    logic [N_BUTTONS-1:0] r_btn_edge;
    logic [SEG_W-1:0]     r_seg;

    mmio_sel_t            w_sel;
    logic [DATA_W-1:0]    w_wmask;
    logic [DATA_W-1:0]    w_rd_data;
    logic [N_BUTTONS-1:0] w_btn_state;
    logic [N_BUTTONS-1:0] w_btn_rise;
    logic [N_BUTTONS-1:0] w_edge_clr;

    button_conditioner #(
        .N_BUTTONS       (N_BUTTONS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_btn   (button_array),
        .o_state (w_btn_state),
        .o_rise  (w_btn_rise)
    );

    always_comb begin
        w_sel = SEL_RAM;
        if      (mem_addr == A_BTN_STATE) w_sel = SEL_BTN_STATE;
        else if (mem_addr == A_BTN_EDGE)  w_sel = SEL_BTN_EDGE;
        else if (mem_addr == A_SEG)       w_sel = SEL_SEG;
        else if (mem_addr == A_RSVD)      w_sel = SEL_RSVD;
    end

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < NB; b++) w_wmask[8*b +: 8] = {8{byte_en[b]}};
    end

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            SEL_RAM:       w_rd_data = r_ram[mem_addr];
            SEL_BTN_STATE: w_rd_data = DATA_W'(w_btn_state);
            SEL_BTN_EDGE:  w_rd_data = DATA_W'(r_btn_edge);
            SEL_SEG:       w_rd_data = DATA_W'(r_seg);
            default:       w_rd_data = '0;
        endcase
    end

    // RAM has no reset; a masked merge keeps untouched bytes
    always_ff @(posedge clk) begin
        if (write_enable && w_sel == SEL_RAM)
            r_ram[mem_addr] <= (r_ram[mem_addr] & ~w_wmask) | (data_in & w_wmask);
    end

    // Read port samples pre-write contents, giving read-first behaviour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out   <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= read_enable;
            if (read_enable) r_data_out <= w_rd_data;
        end
    end

    assign w_edge_clr = (write_enable && w_sel == SEL_BTN_EDGE)
                      ? (data_in[N_BUTTONS-1:0] & w_wmask[N_BUTTONS-1:0]) : '0;

    // New edges are OR-ed after the clear so a same-cycle set wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_edge <= '0;
            r_seg      <= '0;
        end else begin
            r_btn_edge <= (r_btn_edge & ~w_edge_clr) | w_btn_rise;
            if (write_enable && w_sel == SEL_SEG)
                r_seg <= (r_seg & ~w_wmask[SEG_W-1:0]) | (data_in[SEG_W-1:0] & w_wmask[SEG_W-1:0]);
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_SEG; k++) begin : g_seg
            assign seg[7*k +: 7] = hex_to_seg(r_seg[4*k +: 4]);
        end
    endgenerate

    assign data_out   = r_data_out;
    assign read_valid = r_read_valid;

endmodule

// File: tb/tb_memory_v3.sv
// Directed self-checking bench for memory_v3 (default parameters).
module tb_memory_v3;

`ifdef MEMORY_V3_DEBOUNCE_EN
    localparam int BTN_LAT = 2 + 16;
`else
    localparam int BTN_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  mem_addr;
    logic [31:0] data_in;
    logic [3:0]  byte_en;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] data_out;
    logic        read_valid;
    logic [3:0]  button_array;
    logic [13:0] seg;

    int total = 0;
    int bad   = 0;

    memory_v3 dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .data_in      (data_in),
        .byte_en      (byte_en),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .read_valid   (read_valid),
        .button_array (button_array),
        .seg          (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_addr = a; data_in = d; byte_en = be;
        write_enable = 1'b1; read_enable = 1'b0;
        @(posedge clk); #1;
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        mem_addr = a; write_enable = 1'b0; read_enable = 1'b1;
        @(posedge clk); #1;
        read_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_addr = '0; data_in = '0; byte_en = '0;
        write_enable = 1'b0; read_enable = 1'b0; button_array = '0;
        idle(2);
        rst = 1'b0;
        idle(1);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_read_valid", {31'b0, read_valid}, 32'h0);
        chk("rst_seg", {18'b0, seg}, 32'h1FBF);
        rd(10'h3FC);
        chk("rst_btn_state", data_out, 32'h0);
        chk("rv_pulse", {31'b0, read_valid}, 32'h1);
        idle(1);
        chk("rv_drop", {31'b0, read_valid}, 32'h0);

        // Byte strobes
        wr(10'd5, 32'hDEADBEEF, 4'hF);
        wr(10'd5, 32'h00001200, 4'b0010);
        rd(10'd5);
        chk("byte_strobe_rv", {31'b0, read_valid}, 32'h1);
        chk("byte_strobe_data", data_out, 32'hDEAD12EF);
        wr(10'd5, 32'hFFFFFFFF, 4'h0);
        rd(10'd5);
        chk("be_zero_noop", data_out, 32'hDEAD12EF);

        // Read-first on collision, then back-to-back reads
        wr(10'd7, 32'h22, 4'hF);
        mem_addr = 10'd7; data_in = 32'h11; byte_en = 4'hF;
        write_enable = 1'b1; read_enable = 1'b1;
        @(posedge clk); #1;
        write_enable = 1'b0;
        chk("rw_collide_old", data_out, 32'h22);
        @(posedge clk); #1;
        chk("rw_next_new", data_out, 32'h11);
        chk("b2b_rv", {31'b0, read_valid}, 32'h1);
        mem_addr = 10'd5;
        @(posedge clk); #1;
        read_enable = 1'b0;
        chk("b2b_third", data_out, 32'hDEAD12EF);

        // Seven-segment register and reserved word
        wr(10'h3FE, 32'h000000A3, 4'hF);
        chk("seg_digit0", {25'b0, seg[6:0]}, 32'h4F);
        chk("seg_digit1", {25'b0, seg[13:7]}, 32'h77);
        rd(10'h3FE);
        chk("seg_readback", data_out, 32'hA3);
        wr(10'h3FE, 32'h0000001F, 4'b0010);
        rd(10'h3FE);
        chk("seg_masked_write", data_out, 32'hA3);
        wr(10'h3FF, 32'hFFFFFFFF, 4'hF);
        rd(10'h3FF);
        chk("rsvd_reads_zero", data_out, 32'h0);
        wr(10'h3FC, 32'hF, 4'hF);
        rd(10'h3FC);
        chk("btn_state_ro", data_out, 32'h0);

        // Button latency and edge flags
        button_array = 4'b0100;
        for (int i = 0; i < BTN_LAT; i++) begin
            rd(10'h3FC);
            chk("btn_state_early", data_out, 32'h0);
        end
        rd(10'h3FC);
        chk("btn_state_set", data_out, 32'h4);
        rd(10'h3FD);
        chk("btn_edge_set", data_out, 32'h4);
        wr(10'h3FD, 32'h4, 4'h0);
        rd(10'h3FD);
        chk("edge_clr_be0", data_out, 32'h4);
        wr(10'h3FD, 32'h4, 4'hF);
        rd(10'h3FD);
        chk("edge_clr_w1c", data_out, 32'h0);

`ifdef MEMORY_V3_DEBOUNCE_EN
        button_array = 4'b0101;
        idle(5);
        button_array = 4'b0100;
        idle(25);
        rd(10'h3FC);
        chk("glitch_state", data_out, 32'h4);
        rd(10'h3FD);
        chk("glitch_edge", data_out, 32'h0);
`endif

        // Re-arm an edge, then reset in the middle of a read
        button_array = 4'b0000;
        idle(BTN_LAT + 3);
        button_array = 4'b0100;
        idle(BTN_LAT + 3);
        rd(10'h3FD);
        chk("edge_rearm", data_out, 32'h4);
        mem_addr = 10'd5; read_enable = 1'b1;
        @(posedge clk); #1;
        read_enable = 1'b0;
        chk("pre_rst_rv", {31'b0, read_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rv", {31'b0, read_valid}, 32'h0);
        chk("async_rst_data", data_out, 32'h0);
        chk("async_rst_edge", {28'b0, dut.r_btn_edge}, 32'h0);
        chk("async_rst_seg", {18'b0, seg}, 32'h1FBF);
        idle(2);
        rst = 1'b0;
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_v3.md
# memory_v3

Parametrised data memory with memory-mapped I/O for the RISC-V core. Combines a word-addressed RAM with byte write strobes, a registered read port with a valid strobe, and a small MMIO window at the top of the address space. The window holds conditioned push-button state, sticky button-edge flags and a seven-segment display register. It sits on the core's load/store path and drives the board buttons and displays.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8.
- `ADDR_W`, 10: word-address width; depth is 2^ADDR_W words.
- `N_BUTTONS`, 4: push-button count; ≤ DATA_W.
- `N_SEG`, 2: seven-segment digit count; 4*N_SEG ≤ DATA_W.
- `DEBOUNCE_CYCLES`, 16: stable cycles required per button change; used only with `MEMORY_V3_DEBOUNCE_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_addr` in ADDR_W: word address.
- `data_in` in DATA_W: write data.
- `byte_en` in DATA_W/8: per-byte write strobe.
- `write_enable` in 1: write request this cycle.
- `read_enable` in 1: read request this cycle.
- `data_out` out DATA_W: registered read data; held until the next read.
- `read_valid` out 1: pulses for one cycle when `data_out` carries the result of the previous cycle's read.
- `button_array` in N_BUTTONS: raw, asynchronous button inputs.
- `seg` out 7*N_SEG: digit k is `seg[7k+6:7k]`, encoded gfedcba, active-high.

## Operation
- The address map uses the top four words for MMIO; all other addresses are RAM:
  - `2^ADDR_W-4` (0x3FC): BTN_STATE. Read-only conditioned button levels in bits [N_BUTTONS-1:0]; writes are ignored.
  - `2^ADDR_W-3` (0x3FD): BTN_EDGE. Sticky rising-edge flags, write-1-to-clear.
  - `2^ADDR_W-2` (0x3FE): SEG_REG. Read/write; nibble k, bits [4k+3:4k], drives digit k as a hex glyph.
  - `2^ADDR_W-1` (0x3FF): reserved. Reads 0; writes are ignored.
- RAM and SEG_REG writes update only the bytes whose `byte_en` bit is 1. `byte_en` = 0 makes a write a no-op.
- BTN_EDGE clear: a flag clears only if its data bit is 1 and its containing byte is enabled.
- Simultaneous new edge and clear on the same flag: set wins and the flag stays 1.
- Simultaneous read and write to the same address: read-first. `data_out` returns the old contents.
- Button path, per bit: 2-flop synchronizer, then optional debounce, then rising-edge detect into BTN_EDGE.
- Unused upper bits of BTN_STATE, BTN_EDGE and SEG_REG read as 0.
- Hex glyphs: 0→7'h3F, 1→7'h06, A→7'h77, F→7'h71 (standard table in the package).

## Timing
- Write: commits at the rising edge where `write_enable`=1. A read in the next cycle sees the new value.
- Read: when `read_enable`=1 at edge N, `data_out` and `read_valid`=1 appear after edge N. `read_valid` drops after edge N+1 unless another read is issued.
- Back-to-back reads sustain one result per cycle.
- Button to BTN_STATE latency:
  - without debounce: 2 cycles;
  - with debounce: 2 + DEBOUNCE_CYCLES cycles.
- BTN_EDGE sets one cycle after BTN_STATE rises.
- Reset values:
  - `data_out`=0, `read_valid`=0;
  - BTN_STATE=0, BTN_EDGE=0, synchronizers=0, debounce counters=0;
  - SEG_REG=0, so every digit shows 7'h3F.
  - RAM contents are not reset.
- Reset asserted mid-read: `read_valid` deasserts immediately and the pending read is dropped.
- Reset asserted mid-write: the write is not guaranteed to commit.

## Configuration
- `MEMORY_V3_DEBOUNCE_EN` defined: each button keeps a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronized input differs from the stable state.
  - It resets to 0 when the input matches the stable state.
  - The stable state flips, and the counter clears, when the count reaches DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches BTN_STATE.
- `MEMORY_V3_DEBOUNCE_EN` undefined: BTN_STATE is the synchronized input; no counters are instantiated.

## Structure
- `memory_v3_pkg` holds:
  - the MMIO offset constants: BTN_STATE_OFS=4, BTN_EDGE_OFS=3, SEG_REG_OFS=2, RSVD_OFS=1, each subtracted from 2^ADDR_W;
  - the hex-to-segment lookup function;
  - the `mmio_sel_t` enum {SEL_RAM, SEL_BTN_STATE, SEL_BTN_EDGE, SEL_SEG, SEL_RSVD}.
- Sub-module `button_conditioner`: parametrised by N_BUTTONS and DEBOUNCE_CYCLES. Contains the synchronizer, the optional debounce and the edge pulse output.
- RAM, address decode, the read mux and the MMIO registers stay in the top level.

## Test plan
- Reset, then idle: `data_out`=0, `read_valid`=0, `seg`=14'h1FBF (both digits 7'h3F), BTN_STATE reads 0.
- Write 0xDEADBEEF to addr 5 with `byte_en`=4'hF, then with `byte_en`=4'b0010 write 0x00001200, then read addr 5 → `read_valid` one cycle later, `data_out`=0xDEAD12EF.
- Read addr 7 and write 0x11 to addr 7 in the same cycle, where addr 7 previously held 0x22 → `data_out`=0x22; the next read returns 0x11.
- Write 0x0000_00A3 to 0x3FE → `seg`[6:0]=7'h4F ('3'), `seg`[13:7]=7'h77 ('A'); reading 0x3FE returns 0xA3.
- Drive `button_array`=4'b0100 → BTN_STATE=0x4 after 2 cycles (2+16 with debounce); BTN_EDGE=0x4. Write 0x4 to 0x3FD → BTN_EDGE=0. With debounce, a 5-cycle pulse on bit 0 leaves BTN_STATE=0.
- Assert `rst` during a read while BTN_EDGE=0x4 → `read_valid`=0 and BTN_EDGE=0 immediately, without waiting for a clock edge.
